// File: rtl/fitbit_pkg.sv
// Shared types for the step tracker: edge-FSM states, display modes,
// statistic widths and saturating-increment helpers.
package fitbit_pkg;

    localparam int TOTAL_W     = 20;
    localparam int ACTIVE_W    = 16;
    localparam int SEC_STEPS_W = 8;
    localparam int ELAPSED_W   = 20;

    typedef enum logic [1:0] {
        EDGE_LOW      = 2'd0,
        EDGE_DEB_HIGH = 2'd1,
        EDGE_HIGH     = 2'd2,
        EDGE_DEB_LOW  = 2'd3
    } edge_state_e;

    typedef enum logic [1:0] {
        DISP_TOTAL    = 2'd0,
        DISP_ACTIVE   = 2'd1,
        DISP_LAST_SEC = 2'd2,
        DISP_ELAPSED  = 2'd3
    } disp_mode_e;

    // Long-lived statistics, registered together.
    typedef struct packed {
        logic [TOTAL_W-1:0]     total;
        logic [ACTIVE_W-1:0]    active;
        logic [SEC_STEPS_W-1:0] last_sec;
        logic [ELAPSED_W-1:0]   elapsed;
    } stats_t;

    function automatic logic [19:0] sat_inc20(input logic [19:0] v);
        return (&v) ? v : v + 20'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    function automatic disp_mode_e next_mode(input disp_mode_e m);
        case (m)
            DISP_TOTAL:    return DISP_ACTIVE;
            DISP_ACTIVE:   return DISP_LAST_SEC;
            DISP_LAST_SEC: return DISP_ELAPSED;
            default:       return DISP_TOTAL;
        endcase
    endfunction

endpackage

// File: rtl/step_tracker_ctrl_if.sv
// Step strobe link from the debouncer (master) to the statistics logic (slave).
interface step_tracker_ctrl_if;
    import fitbit_pkg::*;

    logic step_pulse;

    modport master (output step_pulse);
    modport slave  (input  step_pulse);

endinterface

// File: rtl/step_debounce.sv
// Synchronizes the raw sensor level, debounces both edges and emits a
// one-cycle strobe when a debounced rising edge is accepted.
module step_debounce
    import fitbit_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       pulse_i,
    step_tracker_ctrl_if.master        step_if
);

    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic          lvl;
    edge_state_e   state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          step_q, step_d;

    assign lvl = sync_q[1];

    // Two-flop synchronizer for the asynchronous sensor input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b00;
        else         sync_q <= {sync_q[0], pulse_i};
    end

    // Edge FSM and debounce counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EDGE_LOW;
            cnt_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
        end
    end

    // Next state: a level must persist DEBOUNCE_CYC cycles in DEB_* to be accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            EDGE_LOW: begin
                if (lvl) begin
                    state_d = EDGE_DEB_HIGH;
                    cnt_d   = '0;
                end
            end
            EDGE_DEB_HIGH: begin
                if (!lvl)                  state_d = EDGE_LOW;
                else if (cnt_q == DEB_LAST) state_d = EDGE_HIGH;
                else                        cnt_d   = cnt_q + DW'(1);
            end
            EDGE_HIGH: begin
                if (!lvl) begin
                    state_d = EDGE_DEB_LOW;
                    cnt_d   = '0;
                end
            end
            EDGE_DEB_LOW: begin
                if (lvl)                    state_d = EDGE_HIGH;
                else if (cnt_q == DEB_LAST) state_d = EDGE_LOW;
                else                        cnt_d   = cnt_q + DW'(1);
            end
            default: state_d = EDGE_LOW;
        endcase
        // Only a confirmed rise counts; bouncing back from DEB_LOW is not a new step.
        step_d = (state_q == EDGE_DEB_HIGH) && (state_d == EDGE_HIGH);
    end

    assign step_if.step_pulse = step_q;

endmodule

// File: rtl/step_tracker_ctrl.sv
// Step tracker: debounced step counting, per-second activity statistics
// and a rotating display selector.
module step_tracker_ctrl
    import fitbit_pkg::*;
#(
    parameter int CLKS_PER_SEC  = 100_000_000,
    parameter int DEBOUNCE_CYC  = 1_000_000,
    parameter int DISP_SEC      = 2,
    parameter int ACTIVE_THRESH = 2
) (
    input  logic        clk100MHz,
    input  logic        reset_n,
    input  logic        pulse_in,
    input  logic        clear,
    output logic        step_pulse,
    output logic        sec_tick,
    output logic [19:0] total_steps,
    output logic [15:0] active_secs,
    output logic [1:0]  disp_mode,
    output logic [19:0] disp_value
);

    localparam int SEC_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLKS_PER_SEC - 1);
    localparam int DSP_W = (DISP_SEC > 1) ? $clog2(DISP_SEC) : 1;
    localparam logic [DSP_W-1:0] DSP_LAST = DSP_W'(DISP_SEC - 1);
    localparam logic [SEC_STEPS_W-1:0] THRESH = SEC_STEPS_W'(ACTIVE_THRESH);

    step_tracker_ctrl_if deb_if ();

    step_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_step_debounce (
        .clk_i   (clk100MHz),
        .rst_ni  (reset_n),
        .pulse_i (pulse_in),
        .step_if (deb_if)
    );

    logic                   step, tick;
    logic [SEC_W-1:0]       sec_cnt_q, sec_cnt_d;
    logic [SEC_STEPS_W-1:0] sec_steps_q, sec_steps_d, closing;
    stats_t                 stats_q, stats_d;
    logic [DSP_W-1:0]       disp_cnt_q, disp_cnt_d;
    disp_mode_e             disp_mode_q, disp_mode_d;
    logic [19:0]            disp_value_q, disp_value_d;

    assign step = deb_if.step_pulse;
    assign tick = (sec_cnt_q == SEC_LAST);

    // Statistics, timebase and display registers.
    always_ff @(posedge clk100MHz or negedge reset_n) begin
        if (!reset_n) begin
            sec_cnt_q    <= '0;
            sec_steps_q  <= '0;
            stats_q      <= '0;
            disp_cnt_q   <= '0;
            disp_mode_q  <= DISP_TOTAL;
            disp_value_q <= '0;
        end else begin
            sec_cnt_q    <= sec_cnt_d;
            sec_steps_q  <= sec_steps_d;
            stats_q      <= stats_d;
            disp_cnt_q   <= disp_cnt_d;
            disp_mode_q  <= disp_mode_d;
            disp_value_q <= disp_value_d;
        end
    end

    // Next-state for counters; clear overrides any coincident step or tick.
    always_comb begin
        sec_cnt_d   = sec_cnt_q;
        sec_steps_d = sec_steps_q;
        stats_d     = stats_q;
        disp_cnt_d  = disp_cnt_q;
        disp_mode_d = disp_mode_q;
        // A step in the tick cycle still belongs to the second that is closing.
        closing     = step ? sat_inc8(sec_steps_q) : sec_steps_q;

        if (clear) begin
            sec_cnt_d   = '0;
            sec_steps_d = '0;
            stats_d     = '0;
            disp_cnt_d  = '0;
            disp_mode_d = DISP_TOTAL;
        end else begin
            sec_cnt_d = tick ? '0 : sec_cnt_q + SEC_W'(1);
            if (step) stats_d.total = sat_inc20(stats_q.total);
            if (tick) begin
                sec_steps_d      = '0;
                stats_d.last_sec = closing;
                stats_d.elapsed  = sat_inc20(stats_q.elapsed);
                if (closing >= THRESH) stats_d.active = sat_inc16(stats_q.active);
                if (disp_cnt_q == DSP_LAST) begin
                    disp_cnt_d  = '0;
                    disp_mode_d = next_mode(disp_mode_q);
                end else begin
                    disp_cnt_d  = disp_cnt_q + DSP_W'(1);
                end
            end else begin
                sec_steps_d = closing;
            end
        end
    end

    // Display value is registered from the current mode and statistics.
    always_comb begin
        disp_value_d = '0;
        case (disp_mode_q)
            DISP_TOTAL:    disp_value_d = stats_q.total;
            DISP_ACTIVE:   disp_value_d = {4'd0, stats_q.active};
            DISP_LAST_SEC: disp_value_d = {12'd0, stats_q.last_sec};
            default:       disp_value_d = stats_q.elapsed;
        endcase
    end

    assign step_pulse  = step;
    assign sec_tick    = tick;
    assign total_steps = stats_q.total;
    assign active_secs = stats_q.active;
    assign disp_mode   = disp_mode_q;
    assign disp_value  = disp_value_q;

endmodule
